reg_file_box_mp: RTL and testbench



---
 rtl/rfb_pkg.sv | 19 +
 rtl/rfb_scoreboard.sv | 50 +++++
 rtl/reg_file_box_mp.sv | 117 +++++++++++
 tb/tb_reg_file_box_mp.sv | 227 ++++++++++++++++++++++
 4 files changed

// File: rtl/rfb_pkg.sv
// Shared definitions for the multi-port register file: default sizes,
// controller state encoding and packed-bus width helper.
package rfb_pkg;

   localparam int unsigned RFB_XLEN  = 32;
   localparam int unsigned RFB_NREGS = 32;
   localparam int unsigned RFB_AW    = 5;

   typedef enum logic {
      RFB_CLEAR = 1'b0,
      RFB_RUN   = 1'b1
   } rfb_state_e;

   // Width of a bus carrying n fields of w bits each, field i at [i*w +: w].
   function automatic int unsigned rfb_bus_w(input int unsigned n, input int unsigned w);
      return n * w;
   endfunction

endpackage

// File: rtl/rfb_scoreboard.sv
// Per-register busy scoreboard: write-backs clear, issued producers set.
// A set wins over a clear on the same register because the new producer is younger.
module rfb_scoreboard
   import rfb_pkg::*;
#(
   parameter int unsigned NREGS = RFB_NREGS,
   parameter int unsigned AW    = RFB_AW,
   parameter int unsigned NWR   = 1
) (
   input  logic                           clk,
   input  logic                           rst,
   input  logic                           run,
   input  logic [NWR-1:0]                 wr_en,
   input  logic [rfb_bus_w(NWR, AW)-1:0]  wr_addr,
   input  logic                           set_en,
   input  logic [AW-1:0]                  set_addr,
   output logic [NREGS-1:0]               busy
);

   logic [NREGS-1:0] busy_q;
   logic [NREGS-1:0] busy_d;

   // Next busy vector: clears first, then the set so it takes priority.
   always_comb begin
      busy_d = busy_q;
      if (run) begin
         for (int j = 0; j < int'(NWR); j++) begin
            if (wr_en[j]) begin
               busy_d[wr_addr[j*AW +: AW]] = 1'b0;
            end
         end
         if (set_en) begin
            busy_d[set_addr] = 1'b1;
         end
      end
      busy_d[0] = 1'b0;
   end

   // Busy state register.
   always_ff @(posedge clk) begin
      if (rst) begin
         busy_q <= '0;
      end else begin
         busy_q <= busy_d;
      end
   end

   assign busy = busy_q;

endmodule

// File: rtl/reg_file_box_mp.sv
// Multi-port register file with write-to-read bypass, busy scoreboard and a
// post-reset clear sequence that zeroes one register per cycle before ready.
module reg_file_box_mp
   import rfb_pkg::*;
#(
   parameter int unsigned XLEN  = RFB_XLEN,
   parameter int unsigned NREGS = RFB_NREGS,
   parameter int unsigned AW    = RFB_AW,
   parameter int unsigned NRD   = 2,
   parameter int unsigned NWR   = 1
) (
   input  logic                            clk,
   input  logic                            rst,
   input  logic [rfb_bus_w(NRD, AW)-1:0]   rd_addr,
   output logic [rfb_bus_w(NRD, XLEN)-1:0] rd_data,
   output logic [NRD-1:0]                  rd_busy,
   input  logic [NWR-1:0]                  wr_en,
   input  logic [rfb_bus_w(NWR, AW)-1:0]   wr_addr,
   input  logic [rfb_bus_w(NWR, XLEN)-1:0] wr_data,
   input  logic                            sb_set_en,
   input  logic [AW-1:0]                   sb_set_addr,
   output logic                            ready
);

   rfb_state_e       state_q;
   rfb_state_e       state_d;
   logic [AW-1:0]    cnt_q;
   logic [AW-1:0]    cnt_d;
   logic [XLEN-1:0]  regs [NREGS];
   logic [NREGS-1:0] busy;
   logic             run;

   assign run   = (state_q == RFB_RUN);
   assign ready = run;

   // Clear sequencer: walk registers 1..NREGS-1, then enter RUN.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      if (state_q == RFB_CLEAR) begin
         cnt_d = cnt_q + AW'(1);
         if (cnt_q == AW'(NREGS - 1)) begin
            state_d = RFB_RUN;
         end
      end
   end

   // Controller state register; reset restarts the clear from register 1.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= RFB_CLEAR;
         cnt_q   <= AW'(1);
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
      end
   end

   // Register storage: clear writes in CLEAR, port writes in RUN (later port wins).
   always_ff @(posedge clk) begin
      if (!rst) begin
         if (state_q == RFB_CLEAR) begin
            regs[cnt_q] <= '0;
         end else begin
            for (int j = 0; j < int'(NWR); j++) begin
               if (wr_en[j] && (wr_addr[j*AW +: AW] != '0)) begin
                  regs[wr_addr[j*AW +: AW]] <= wr_data[j*XLEN +: XLEN];
               end
            end
         end
      end
   end

   rfb_scoreboard #(
      .NREGS (NREGS),
      .AW    (AW),
      .NWR   (NWR)
   ) u_scoreboard (
      .clk      (clk),
      .rst      (rst),
      .run      (run),
      .wr_en    (wr_en),
      .wr_addr  (wr_addr),
      .set_en   (sb_set_en),
      .set_addr (sb_set_addr),
      .busy     (busy)
   );

   // Read mux with same-cycle bypass; a bypass hit also hides the busy bit.
   always_comb begin
      logic [AW-1:0]   ra;
      logic [XLEN-1:0] rdat;
      logic            hit;
      rd_data = '0;
      rd_busy = '0;
      ra      = '0;
      rdat    = '0;
      hit     = 1'b0;
      for (int i = 0; i < int'(NRD); i++) begin
         ra   = rd_addr[i*AW +: AW];
         rdat = '0;
         hit  = 1'b0;
         if (run && (ra != '0)) begin
            rdat = regs[ra];
            for (int j = 0; j < int'(NWR); j++) begin
               if (wr_en[j] && (wr_addr[j*AW +: AW] == ra)) begin
                  rdat = wr_data[j*XLEN +: XLEN];
                  hit  = 1'b1;
               end
            end
            rd_busy[i] = busy[ra] & ~hit;
         end
         rd_data[i*XLEN +: XLEN] = rdat;
      end
   end

endmodule

// File: tb/tb_reg_file_box_mp.sv
// Randomised scoreboard bench for reg_file_box_mp with two read and two write ports.
module tb_reg_file_box_mp;

   localparam int XLEN  = 32;
   localparam int NREGS = 32;
   localparam int AW    = 5;
   localparam int NRD   = 2;
   localparam int NWR   = 2;

   logic                 clk = 1'b0;
   logic                 rst;
   logic [NRD*AW-1:0]    rd_addr;
   logic [NRD*XLEN-1:0]  rd_data;
   logic [NRD-1:0]       rd_busy;
   logic [NWR-1:0]       wr_en;
   logic [NWR*AW-1:0]    wr_addr;
   logic [NWR*XLEN-1:0]  wr_data;
   logic                 sb_set_en;
   logic [AW-1:0]        sb_set_addr;
   logic                 ready;

   always #5 clk = ~clk;

   reg_file_box_mp #(
      .XLEN  (XLEN),
      .NREGS (NREGS),
      .AW    (AW),
      .NRD   (NRD),
      .NWR   (NWR)
   ) dut (
      .clk         (clk),
      .rst         (rst),
      .rd_addr     (rd_addr),
      .rd_data     (rd_data),
      .rd_busy     (rd_busy),
      .wr_en       (wr_en),
      .wr_addr     (wr_addr),
      .wr_data     (wr_data),
      .sb_set_en   (sb_set_en),
      .sb_set_addr (sb_set_addr),
      .ready       (ready)
   );

   typedef struct packed {
      logic [31:0] d0;
      logic [31:0] d1;
      logic [1:0]  busy;
      logic        rdy;
   } exp_t;

   exp_t q[$];
   int   checks = 0;
   int   errors = 0;

   // Reference model: architectural register contents and busy flags.
   logic [31:0] m_regs [NREGS];
   bit          m_busy [NREGS];
   bit          m_run;
   int          m_left;  // registers still to be zeroed by the clear sequence

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, req, $time);
      end
   endtask

   // Monitor: outputs are combinational, compare one expectation per cycle.
   initial begin
      exp_t e;
      forever begin
         @(negedge clk);
         if (q.size() != 0) begin
            e = q.pop_front();
            check("rd_data0", rd_data[31:0], e.d0);
            check("rd_data1", rd_data[63:32], e.d1);
            check("rd_busy", {30'd0, rd_busy}, {30'd0, e.busy});
            check("ready", {31'd0, ready}, {31'd0, e.rdy});
         end
      end
   end

   task automatic model_reset();
      m_run  = 1'b0;
      m_left = NREGS - 1;
      for (int k = 0; k < NREGS; k++) m_busy[k] = 1'b0;
   endtask

   // One clock cycle: drive, predict, push, then advance the model across the edge.
   task automatic do_cycle(input bit r, input bit [1:0] we, input int wa0, input int wa1,
                           input logic [31:0] wd0, input logic [31:0] wd1,
                           input bit sbe, input int sba, input int ra0, input int ra1);
      exp_t        e;
      int          wa [2];
      logic [31:0] wd [2];
      int          ra [2];
      logic [31:0] d  [2];
      bit          b  [2];
      wa[0] = wa0; wa[1] = wa1; wd[0] = wd0; wd[1] = wd1; ra[0] = ra0; ra[1] = ra1;
      rst         = r;
      wr_en       = we;
      wr_addr     = {5'(wa1), 5'(wa0)};
      wr_data     = {wd1, wd0};
      sb_set_en   = sbe;
      sb_set_addr = 5'(sba);
      rd_addr     = {5'(ra1), 5'(ra0)};
      for (int i = 0; i < 2; i++) begin
         d[i] = 32'd0;
         b[i] = 1'b0;
         if (m_run && ra[i] != 0) begin
            d[i] = m_regs[ra[i]];
            b[i] = m_busy[ra[i]];
            for (int j = 0; j < 2; j++) begin
               if (we[j] && wa[j] == ra[i]) begin
                  d[i] = wd[j];
                  b[i] = 1'b0;
               end
            end
         end
      end
      e.d0 = d[0]; e.d1 = d[1]; e.busy = {b[1], b[0]}; e.rdy = m_run;
      q.push_back(e);
      @(posedge clk);
      if (r) begin
         model_reset();
      end else if (!m_run) begin
         m_regs[NREGS - m_left] = 32'd0;
         m_left--;
         if (m_left == 0) m_run = 1'b1;
      end else begin
         for (int j = 0; j < 2; j++) begin
            if (we[j] && wa[j] != 0) begin
               m_regs[wa[j]] = wd[j];
               m_busy[wa[j]] = 1'b0;
            end
         end
         if (sbe && sba != 0) m_busy[sba] = 1'b1;
      end
      #1;
   endtask

   task automatic idle(input int ra0, input int ra1);
      do_cycle(1'b0, 2'b00, 0, 0, 32'd0, 32'd0, 1'b0, 0, ra0, ra1);
   endtask

   task automatic wait_ready(output int n);
      n = 0;
      while (!ready && n < 100) begin
         idle(n % NREGS, (n + 7) % NREGS);
         n++;
      end
   endtask

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "timeout");
   end

   initial begin
      int n;
      for (int k = 0; k < NREGS; k++) m_regs[k] = 32'd0;
      rst = 1'b1; wr_en = '0; wr_addr = '0; wr_data = '0;
      sb_set_en = 1'b0; sb_set_addr = '0; rd_addr = '0;
      @(posedge clk);
      model_reset();
      #1;

      // Clear sequence with a write and a busy-set to r5 that must be ignored.
      n = 0;
      while (!ready && n < 100) begin
         do_cycle(1'b0, 2'b01, 5, 0, 32'h55, 32'd0, 1'b1, 5, 5, 3);
         n++;
      end
      check("clear_len", n, 31);
      for (int k = 0; k < 16; k++) idle(k, k + 16);

      // Basic write/read and the hard-wired zero register.
      do_cycle(1'b0, 2'b01, 3, 0, 32'hDEADBEEF, 32'd0, 1'b0, 0, 0, 0);
      idle(3, 0);
      do_cycle(1'b0, 2'b01, 0, 0, 32'h1234, 32'd0, 1'b0, 0, 0, 0);
      idle(0, 3);

      // Bypass: r7 old value, then same-cycle write seen on port 1.
      do_cycle(1'b0, 2'b01, 7, 0, 32'h11111111, 32'd0, 1'b0, 0, 0, 0);
      do_cycle(1'b0, 2'b10, 0, 7, 32'd0, 32'hA5A5A5A5, 1'b0, 0, 3, 7);
      idle(7, 7);

      // Write conflict: higher port wins in bypass and in storage.
      do_cycle(1'b0, 2'b11, 9, 9, 32'd1, 32'd2, 1'b0, 0, 9, 9);
      idle(9, 1);

      // Scoreboard set, set-over-clear, plain clear with bypass hiding.
      do_cycle(1'b0, 2'b00, 0, 0, 32'd0, 32'd0, 1'b1, 4, 4, 0);
      idle(4, 4);
      do_cycle(1'b0, 2'b01, 4, 0, 32'h44, 32'd0, 1'b1, 4, 4, 0);
      idle(4, 0);
      do_cycle(1'b0, 2'b10, 0, 4, 32'd0, 32'h45, 1'b0, 0, 4, 4);
      idle(4, 4);

      // Random traffic with occasional resets.
      for (int k = 0; k < 500; k++) begin
         do_cycle(($urandom_range(0, 99) == 0), 2'($urandom_range(0, 3)),
                  $urandom_range(0, NREGS - 1), $urandom_range(0, NREGS - 1),
                  $urandom, $urandom, 1'($urandom_range(0, 1)),
                  $urandom_range(0, NREGS - 1),
                  $urandom_range(0, NREGS - 1), $urandom_range(0, NREGS - 1));
      end
      wait_ready(n);

      // Mid-run reset wipes r10 and its busy bit.
      do_cycle(1'b0, 2'b01, 10, 0, 32'd5, 32'd0, 1'b1, 10, 0, 0);
      idle(10, 10);
      do_cycle(1'b1, 2'b00, 0, 0, 32'd0, 32'd0, 1'b0, 0, 10, 0);
      wait_ready(n);
      check("reclear_len", n, 31);
      idle(10, 10);

      @(negedge clk);
      #1;
      check("queue_drained", q.size(), 0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
